gemm_result_drain: RTL

Output stage placed directly downstream of the GEMM array input/compute block. It accepts one N-lane result vector per handshake and requantizes each lane: round-half-up arithmetic right shift, then signed saturation. Vectors are buffered in a small vector FIFO, then serialized one lane per handshake onto a valid/ready stream toward the writeback/storage side.

---
 rtl/gemm_result_drain.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gemm_result_drain.sv
// rtl/gemm_result_drain.sv - requantize GEMM result vectors, buffer them, and serialize one lane per handshake.
// Optional feature: define GEMM_DRAIN_RELU_EN to clamp negative inputs to zero before rounding.
module gemm_result_drain #(
  parameter int N              = 1,
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 8,
  parameter int SHIFT          = 0,
  parameter int DEPTH          = 4,
  localparam int LW            = (N > 1) ? $clog2(N) : 1,
  localparam int CW            = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N*DATA_WIDTH_IN-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH_OUT-1:0]   out_data,
  output logic [LW-1:0]               out_lane,
  output logic                        out_last,
  output logic [CW-1:0]               count
);

  localparam int DI = DATA_WIDTH_IN;
  localparam int DO = DATA_WIDTH_OUT;
  localparam int IW = DATA_WIDTH_IN + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic signed [IW-1:0] RND = IW'((1 << SHIFT) >> 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_d;
  logic [LW-1:0]     lane, lane_d;
  logic [N*DO-1:0]   q_vec;
  logic [N*DO-1:0]   hold;
  logic [N*DO-1:0]   mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop, fire, empty;

  // One extra bit of headroom keeps the rounding add from overflowing.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [DI-1:0] x;
    logic signed [IW-1:0] r;
`ifdef GEMM_DRAIN_RELU_EN
    logic signed [DI-1:0] raw;
    assign raw = in_data[i*DI +: DI];
    assign x   = raw[DI-1] ? '0 : raw;
`else
    assign x = in_data[i*DI +: DI];
`endif
    assign r = ($signed({x[DI-1], x}) + RND) >>> SHIFT;

    if (DO >= IW) begin : g_ext
      assign q_vec[i*DO +: DO] = DO'(r);
    end else begin : g_sat
      localparam logic signed [IW-1:0] MAXV = IW'((1 << (DO - 1)) - 1);
      localparam logic signed [IW-1:0] MINV = ~MAXV;
      logic [DO-1:0] q;
      always_comb begin
        if (r > MAXV)      q = MAXV[DO-1:0];
        else if (r < MINV) q = MINV[DO-1:0];
        else               q = r[DO-1:0];
      end
      assign q_vec[i*DO +: DO] = q;
    end
  end

  // Full is judged from registered occupancy only, so a same-cycle pop never opens in_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign empty     = (count == '0);
  assign push      = in_valid && in_ready;
  assign out_valid = (state == SEND);
  assign fire      = out_valid && out_ready;
  assign out_lane  = lane;
  assign out_last  = out_valid && (lane == LAST_LANE);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      if (lane == LW'(i)) out_data = hold[i*DO +: DO];
    end
  end

  always_comb begin
    state_d = state;
    lane_d  = lane;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          lane_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fire) begin
          if (lane != LAST_LANE) begin
            lane_d = lane + 1'b1;
          end else begin
            lane_d = '0;
            if (!empty) pop = 1'b1;
            else        state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      lane   <= '0;
      hold   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_d;
      lane  <= lane_d;
      if (pop) begin
        hold   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q_vec;
  end

endmodule
